vid_capture_dram_writer: RTL and testbench
==========================================

// Module: vid_capture_dram_writer
// PURPOSE
//  Parametrised successor of the single-format frame grabber. Captures one video frame on request.
//  Packs pixels into 32-bit DRAM write words and emits burst commands (len+addr) to the DRAM write FIFO.
//  Adds over the previous generation:
//   - RGB888 and RGB565 packing.
//   - Double-buffered frame banks.
//   - Active-region clipping.
//   - Command-FIFO overflow detection.
//   - Single clock domain.
// PARAMETERS
//  H_ACTIVE    1600          pixels per line written; extra DE pixels are ignored
//  V_ACTIVE    1200          lines per frame written; extra lines are ignored
//  BURST_LEN   64            max words per ctrl command (1..255)
//  FB_BASE     32'h0000_0000 byte address of bank 0
//  BANK_BYTES  32'h0080_0000 byte offset between bank 0 and bank 1
//  PIX_MODE    0             0: RGB888, 1 word/pixel; 1: RGB565, 2 pixels/word
// PORTS
//  clk           in   1   video/system clock; everything is synchronous to it
//  rst_n         in   1   synchronous, active-low reset
//  hsync         in   1   horizontal sync, active high
//  vsync_n       in   1   vertical sync, active low
//  de            in   1   data enable
//  rgb_data      in   24  pixel, packed {R,B,G}
//  capture_sig   in   1   level; sampled at frame start to arm capture of that frame
//  ctrl_full     in   1   DRAM ctrl FIFO full
//  data_in       out  36  {strb[3:0], data[31:0]}
//  data_we       out  1   data word valid
//  ctrl_in       out  40  {len[7:0], addr[31:0]}; len counts 32-bit words
//  ctrl_we       out  1   command valid
//  capture_rtn   out  1   high during a frame being captured
//  capture_done  out  1   1-cycle pulse when a captured frame completes
//  cur_bank      out  1   bank holding the last completed frame
//  overflow      out  1   sticky: a command was dropped because ctrl_full was high
// BEHAVIOUR
//  Reset: every output is 0. All counters clear and capture is disarmed. A reset mid-frame abandons the frame; no done pulse.
//  Frame start = vsync rising edge, where vsync = ~vsync_n, detected by a 2-flop history.
//   - capture_rtn <= capture_sig.
//   - If capture_rtn was 1: pulse capture_done, toggle cur_bank.
//   - Clear y_cnt and line_addr.
//  cap_de = de & capture_rtn & (x_cnt < H_ACTIVE) & (y_cnt < V_ACTIVE).
//  x_cnt clears on hsync. y_cnt increments on the falling edge of (de & capture_rtn).
//  RGB888 data path:
//   - data = {R,G,B,8'hFF}, strb = 4'hF.
//   - data_we = cap_de, registered, 1-cycle latency.
//  RGB565 data path:
//   - Even pixel is held; odd pixel completes the word {px1,px0}, strb = 4'hF.
//   - A line ending on an even pixel flushes {16'h0,px0} with strb = 4'b0011.
//  Address:
//   - line_addr advances by the line stride in bytes (H_ACTIVE*4, or ceil(H_ACTIVE/2)*4) once per line.
//   - No multiplier.
//   - Command addr = FB_BASE + bank_w*BANK_BYTES + line_addr + burst_start_word*4, where bank_w = ~cur_bank.
//  Burst rule:
//   - Full burst: ctrl_we pulses in the cycle after the data_we that completes BURST_LEN words, with len = BURST_LEN.
//   - Line end with a partial burst: ctrl_we pulses 1 cycle after the last data word, with len = words pending.
//   - A command is never emitted with len = 0.
//   - A burst never spans two lines.
//  Overflow: if ctrl_full = 1 in the cycle ctrl_we would assert, the command is dropped, ctrl_we stays 0, and overflow is set. Only reset clears it.
//  Simultaneous events:
//   - vsync edge together with a pending flush: flush first.
//   - The next frame's counters then reset.
//   - capture_sig changing mid-frame has no effect.
// STRUCTURE
//  Shared package vcap_pkg: PIX_RGB888/PIX_RGB565 constants, STRB_FULL/STRB_LO constants, a {len,addr} ctrl command struct.
//  One sub-module: vcap_pixel_packer (format packing, strobe generation, line-end flush), instantiated per PIX_MODE.
//  Top level holds sync edge detection, counters, burst/address logic, banking and overflow.
// TESTING
//  1. RGB888, H=8, V=2, BURST=4, capture_sig=1:
//     - 16 data words; rgb 24'h112233 -> data 32'h113322FF.
//     - ctrl cmds at addr 0x800000, 0x800010, 0x800020, 0x800030, len 4 each.
//  2. RGB888, H=6, BURST=4:
//     - Per line: cmds len 4 then len 2.
//     - Second line starts at line offset +24.
//  3. RGB565, H=5: 3 words per line; last word has strb 4'b0011 and upper half 0.
//  4. DE for 10 pixels with H=8: only 8 words per line; the extra 2 produce no data_we.
//  5. capture_sig=1 for 2 frames:
//     - capture_done pulses twice.
//     - cur_bank goes 0->1->0.
//     - Second frame's addresses are bank 0 based.
//  6. ctrl_full=1 at a burst boundary: cmd dropped, overflow=1 until rst_n=0. Reset mid-line: all outputs 0, no done pulse.

Source files
------------

// File: rtl/vcap_pkg.sv
// Shared types and constants for the video capture DRAM writer.
// Pixel formats, byte strobes, ctrl command layout and pixel packing helpers.
package vcap_pkg;

  localparam int PIX_RGB888 = 0;
  localparam int PIX_RGB565 = 1;

  localparam logic [3:0] STRB_FULL = 4'hF;
  localparam logic [3:0] STRB_LO   = 4'h3;

  typedef struct packed {
    logic [7:0]  len;
    logic [31:0] addr;
  } ctrl_cmd_t;

  // Input pixels arrive as {R,B,G}
  function automatic logic [31:0] pack888(input logic [23:0] rgb);
    return {rgb[23:16], rgb[7:0], rgb[15:8], 8'hFF};
  endfunction

  function automatic logic [15:0] rgb565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[7:2], rgb[15:11]};
  endfunction

endpackage

// File: rtl/vcap_pixel_packer.sv
// Packs captured pixels into 32-bit DRAM words with byte strobes.
// o_eol marks the cycle in which the last word of a line has been emitted.
module vcap_pixel_packer
  import vcap_pkg::*;
#(
  parameter int PIX_MODE = PIX_RGB888
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_pix_vld,
  input  logic [23:0] i_rgb,
  input  logic        i_line_end,
  output logic        o_we,
  output logic [35:0] o_data,
  output logic        o_eol,
  output logic        o_flush_pend
);

  logic        r_we;
  logic [35:0] r_data;

  assign o_we   = r_we;
  assign o_data = r_data;

  if (PIX_MODE == PIX_RGB565) begin : g_565
    logic [15:0] r_hold;
    logic        r_have;
    logic        r_flush;

    // An odd-length line leaves one pixel held; it goes out a cycle late
    assign o_flush_pend = i_line_end & r_have;
    assign o_eol        = (i_line_end & ~r_have) | r_flush;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_we    <= 1'b0;
        r_data  <= '0;
        r_hold  <= '0;
        r_have  <= 1'b0;
        r_flush <= 1'b0;
      end else begin
        r_we    <= 1'b0;
        r_flush <= 1'b0;
        if (i_pix_vld) begin
          if (r_have) begin
            r_we   <= 1'b1;
            r_data <= {STRB_FULL, rgb565(i_rgb), r_hold};
            r_have <= 1'b0;
          end else begin
            r_hold <= rgb565(i_rgb);
            r_have <= 1'b1;
          end
        end else if (o_flush_pend) begin
          r_we    <= 1'b1;
          r_flush <= 1'b1;
          r_data  <= {STRB_LO, 16'h0000, r_hold};
          r_have  <= 1'b0;
        end else if (i_clr) begin
          r_have <= 1'b0;
        end
      end
    end
  end else begin : g_888
    assign o_flush_pend = 1'b0;
    assign o_eol        = i_line_end;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_we   <= 1'b0;
        r_data <= '0;
      end else begin
        r_we <= i_pix_vld & ~i_clr;
        if (i_pix_vld)
          r_data <= {STRB_FULL, pack888(i_rgb)};
      end
    end
  end

endmodule

// File: rtl/vid_capture_dram_writer.sv
// Single-frame video grabber: packs pixels to DRAM words and issues
// per-line burst commands into double-buffered frame banks.
module vid_capture_dram_writer
  import vcap_pkg::*;
#(
  parameter int          H_ACTIVE   = 1600,
  parameter int          V_ACTIVE   = 1200,
  parameter int          BURST_LEN  = 64,
  parameter logic [31:0] FB_BASE    = 32'h0000_0000,
  parameter logic [31:0] BANK_BYTES = 32'h0080_0000,
  parameter int          PIX_MODE   = PIX_RGB888
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync_n,
  input  logic        de,
  input  logic [23:0] rgb_data,
  input  logic        capture_sig,
  input  logic        ctrl_full,
  output logic [35:0] data_in,
  output logic        data_we,
  output logic [39:0] ctrl_in,
  output logic        ctrl_we,
  output logic        capture_rtn,
  output logic        capture_done,
  output logic        cur_bank,
  output logic        overflow
);

  localparam logic [15:0] H_LIM   = 16'(H_ACTIVE);
  localparam logic [15:0] V_LIM   = 16'(V_ACTIVE);
  localparam logic [7:0]  B_LEN   = 8'(BURST_LEN);
  localparam logic [31:0] B_BYTES = 32'(BURST_LEN * 4);
  localparam logic [31:0] STRIDE  = (PIX_MODE == PIX_RGB565)
                                    ? 32'((H_ACTIVE + 1) / 2 * 4)
                                    : 32'(H_ACTIVE * 4);

  logic        r_vs_d1;
  logic        r_vs_d2;
  logic        r_fs_pend;
  logic        r_cap;
  logic        r_done;
  logic        r_bank;
  logic        r_ovf;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic        r_dce_q;
  logic [31:0] r_line_addr;
  logic [31:0] r_burst_off;
  logic [7:0]  r_pend;
  logic        r_line_has;
  logic        r_cmd_v;
  ctrl_cmd_t   r_cmd;

  logic        w_dce;
  logic        w_cap_de;
  logic        w_line_end;
  logic        w_fs_edge;
  logic        w_fs;
  logic        w_pk_we;
  logic        w_pk_eol;
  logic        w_flush_pend;
  logic [35:0] w_pk_data;
  logic [7:0]  w_cnt;
  logic        w_full;
  logic        w_part;
  logic [31:0] w_bank_base;

  assign w_dce      = de & r_cap;
  assign w_cap_de   = w_dce & (r_x < H_LIM) & (r_y < V_LIM);
  assign w_line_end = r_dce_q & ~w_dce;
  assign w_fs_edge  = r_vs_d1 & ~r_vs_d2;
  // Frame start waits one cycle for a line-end flush to leave the packer
  assign w_fs       = (w_fs_edge | r_fs_pend) & ~w_flush_pend;

  assign w_cnt       = r_pend + {7'd0, w_pk_we};
  assign w_full      = w_pk_we & (w_cnt == B_LEN);
  assign w_part      = w_pk_eol & ~w_full & (w_cnt != 8'd0);
  assign w_bank_base = r_bank ? FB_BASE : FB_BASE + BANK_BYTES;

  vcap_pixel_packer #(
    .PIX_MODE (PIX_MODE)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_fs),
    .i_pix_vld    (w_cap_de),
    .i_rgb        (rgb_data),
    .i_line_end   (w_line_end),
    .o_we         (w_pk_we),
    .o_data       (w_pk_data),
    .o_eol        (w_pk_eol),
    .o_flush_pend (w_flush_pend)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs_d1     <= 1'b0;
      r_vs_d2     <= 1'b0;
      r_fs_pend   <= 1'b0;
      r_cap       <= 1'b0;
      r_done      <= 1'b0;
      r_bank      <= 1'b0;
      r_ovf       <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_dce_q     <= 1'b0;
      r_line_addr <= '0;
      r_burst_off <= '0;
      r_pend      <= '0;
      r_line_has  <= 1'b0;
      r_cmd_v     <= 1'b0;
      r_cmd       <= '0;
    end else begin
      r_vs_d1   <= ~vsync_n;
      r_vs_d2   <= r_vs_d1;
      r_fs_pend <= (w_fs_edge | r_fs_pend) & w_flush_pend;
      r_dce_q   <= w_dce;
      r_done    <= w_fs & r_cap;

      if (w_fs) begin
        r_cap <= capture_sig;
        if (r_cap)
          r_bank <= ~r_bank;
      end

      if (hsync | w_fs)
        r_x <= '0;
      else if (w_dce && r_x < H_LIM)
        r_x <= r_x + 16'd1;

      if (w_fs)
        r_y <= '0;
      else if (w_line_end && r_y < V_LIM)
        r_y <= r_y + 16'd1;

      r_cmd_v <= w_full | w_part;
      if (w_full | w_part) begin
        r_cmd.len  <= w_full ? B_LEN : w_cnt;
        r_cmd.addr <= w_bank_base + r_line_addr + r_burst_off;
      end

      if (r_cmd_v & ctrl_full)
        r_ovf <= 1'b1;

      if (w_fs) begin
        r_pend      <= '0;
        r_burst_off <= '0;
        r_line_addr <= '0;
        r_line_has  <= 1'b0;
      end else if (w_pk_eol) begin
        r_pend      <= '0;
        r_burst_off <= '0;
        r_line_has  <= 1'b0;
        if (r_line_has | w_pk_we)
          r_line_addr <= r_line_addr + STRIDE;
      end else begin
        r_pend <= w_full ? 8'd0 : w_cnt;
        if (w_full)
          r_burst_off <= r_burst_off + B_BYTES;
        if (w_pk_we)
          r_line_has <= 1'b1;
      end
    end
  end

  assign data_in      = w_pk_data;
  assign data_we      = w_pk_we;
  assign ctrl_in      = r_cmd;
  assign ctrl_we      = r_cmd_v & ~ctrl_full;
  assign capture_rtn  = r_cap;
  assign capture_done = r_done;
  assign cur_bank     = r_bank;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_vid_capture_dram_writer.sv
// Bench for vid_capture_dram_writer: three configurations share one video
// stream (RGB888 H=8, RGB888 H=6, RGB565 H=5), all V=2, BURST=4.
module tb_vid_capture_dram_writer;

  typedef struct {
    logic [23:0] rgb;
    logic [31:0] w888;
  } pix_t;

  typedef struct {
    int          dut;
    bit          ctrl;
    logic [39:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsync = 1'b0;
  logic        vsync_n = 1'b1;
  logic        de = 1'b0;
  logic [23:0] rgb_data = '0;
  logic        capture_sig = 1'b0;
  logic        ctrl_full = 1'b0;

  logic [35:0] d_in [3];
  logic        d_we [3];
  logic [39:0] c_in [3];
  logic        c_we [3];
  logic        rtn  [3];
  logic        done [3];
  logic        bank [3];
  logic        ovf  [3];

  pix_t        px [10];
  logic [35:0] exp565 [6];
  ev_t         evq [$];
  ev_t         expq [$];
  int          done_cnt [3];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  vid_capture_dram_writer #(
    .H_ACTIVE(8), .V_ACTIVE(2), .BURST_LEN(4), .PIX_MODE(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync_n(vsync_n),
    .de(de), .rgb_data(rgb_data), .capture_sig(capture_sig),
    .ctrl_full(ctrl_full), .data_in(d_in[0]), .data_we(d_we[0]),
    .ctrl_in(c_in[0]), .ctrl_we(c_we[0]), .capture_rtn(rtn[0]),
    .capture_done(done[0]), .cur_bank(bank[0]), .overflow(ovf[0])
  );

  vid_capture_dram_writer #(
    .H_ACTIVE(6), .V_ACTIVE(2), .BURST_LEN(4), .PIX_MODE(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync_n(vsync_n),
    .de(de), .rgb_data(rgb_data), .capture_sig(capture_sig),
    .ctrl_full(ctrl_full), .data_in(d_in[1]), .data_we(d_we[1]),
    .ctrl_in(c_in[1]), .ctrl_we(c_we[1]), .capture_rtn(rtn[1]),
    .capture_done(done[1]), .cur_bank(bank[1]), .overflow(ovf[1])
  );

  vid_capture_dram_writer #(
    .H_ACTIVE(5), .V_ACTIVE(2), .BURST_LEN(4), .PIX_MODE(1)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync_n(vsync_n),
    .de(de), .rgb_data(rgb_data), .capture_sig(capture_sig),
    .ctrl_full(ctrl_full), .data_in(d_in[2]), .data_we(d_we[2]),
    .ctrl_in(c_in[2]), .ctrl_we(c_we[2]), .capture_rtn(rtn[2]),
    .capture_done(done[2]), .cur_bank(bank[2]), .overflow(ovf[2])
  );

  initial for (int k = 0; k < 3; k++) done_cnt[k] = 0;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      ev_t e;
      e.dut = k;
      if (d_we[k]) begin
        e.ctrl = 1'b0;
        e.val  = {4'h0, d_in[k]};
        evq.push_back(e);
      end
      if (c_we[k]) begin
        e.ctrl = 1'b1;
        e.val  = c_in[k];
        evq.push_back(e);
      end
      if (done[k])
        done_cnt[k]++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add(input int k, input bit c, input logic [39:0] v);
    ev_t e;
    e.dut  = k;
    e.ctrl = c;
    e.val  = v;
    expq.push_back(e);
  endtask

  // Expected data words of one captured line (l=1 uses inverted pixels)
  task automatic add_line(input int l);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = (l == 0) ? px[i].w888 : {~px[i].w888[31:8], 8'hFF};
      add(0, 1'b0, {8'h0F, w});
      if (i < 6)
        add(1, 1'b0, {8'h0F, w});
    end
    for (int j = 0; j < 3; j++)
      add(2, 1'b0, {4'h0, exp565[l * 3 + j]});
  endtask

  task automatic check_events(input string tag);
    logic [39:0] a [$];
    logic [39:0] e [$];
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 2; c++) begin
        string kind;
        kind = (c != 0) ? "cmd" : "data";
        a.delete();
        e.delete();
        foreach (evq[i])
          if (evq[i].dut == k && evq[i].ctrl == (c != 0))
            a.push_back(evq[i].val);
        foreach (expq[i])
          if (expq[i].dut == k && expq[i].ctrl == (c != 0))
            e.push_back(expq[i].val);
        chk($sformatf("%s_u%0d_%s_count", tag, k, kind),
            64'(a.size()), 64'(e.size()));
        for (int i = 0; i < e.size() && i < a.size(); i++)
          chk($sformatf("%s_u%0d_%s%0d", tag, k, kind, i),
              64'(a[i]), 64'(e[i]));
      end
    end
    evq.delete();
    expq.delete();
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_u%0d_data", tag, k), 64'({d_we[k], d_in[k]}), 64'd0);
      chk($sformatf("%s_u%0d_ctrl", tag, k), 64'({c_we[k], c_in[k]}), 64'd0);
      chk($sformatf("%s_u%0d_status", tag, k),
          64'({rtn[k], done[k], bank[k], ovf[k]}), 64'd0);
    end
  endtask

  task automatic vsync_pulse();
    vsync_n = 1'b0;
    tick(3);
    vsync_n = 1'b1;
    tick(4);
  endtask

  task automatic video_line(input bit inv, input int npix);
    hsync = 1'b1;
    tick(2);
    hsync = 1'b0;
    tick(2);
    for (int i = 0; i < npix; i++) begin
      de = 1'b1;
      rgb_data = inv ? ~px[i].rgb : px[i].rgb;
      tick(1);
    end
    de = 1'b0;
    rgb_data = '0;
    tick(8);
  endtask

  initial begin
    px[0] = '{24'h112233, 32'h113322FF};
    px[1] = '{24'hFF0000, 32'hFF0000FF};
    px[2] = '{24'h00FF00, 32'h0000FFFF};
    px[3] = '{24'h0000FF, 32'h00FF00FF};
    px[4] = '{24'h808080, 32'h808080FF};
    px[5] = '{24'h123456, 32'h125634FF};
    px[6] = '{24'hABCDEF, 32'hABEFCDFF};
    px[7] = '{24'h0F0F0F, 32'h0F0F0FFF};
    px[8] = '{24'hDEAD00, 32'hDE00ADFF};
    px[9] = '{24'hBEEF00, 32'hBE00EFFF};
    exp565[0] = 36'hF_F800_1184;
    exp565[1] = 36'hF_07E0_001F;
    exp565[2] = 36'h3_0000_8410;
    exp565[3] = 36'hF_07FF_EE7B;
    exp565[4] = 36'hF_F81F_FFE0;
    exp565[5] = 36'h3_0000_7BEF;

    tick(3);
    @(negedge clk);
    check_idle("reset");
    #1;
    rst_n = 1'b1;
    tick(2);

    // Frame 1: two captured lines plus one clipped line, into bank 1
    capture_sig = 1'b1;
    vsync_pulse();
    capture_sig = 1'b0;
    for (int k = 0; k < 3; k++)
      chk($sformatf("f1_u%0d_rtn", k), 64'(rtn[k]), 64'd1);
    video_line(1'b0, 10);
    video_line(1'b1, 10);
    video_line(1'b0, 10);
    for (int k = 0; k < 3; k++)
      chk($sformatf("f1_u%0d_rtn_hold", k), 64'(rtn[k]), 64'd1);
    add_line(0);
    add_line(1);
    add(0, 1'b1, 40'h04_0080_0000);
    add(0, 1'b1, 40'h04_0080_0010);
    add(0, 1'b1, 40'h04_0080_0020);
    add(0, 1'b1, 40'h04_0080_0030);
    add(1, 1'b1, 40'h04_0080_0000);
    add(1, 1'b1, 40'h02_0080_0010);
    add(1, 1'b1, 40'h04_0080_0018);
    add(1, 1'b1, 40'h02_0080_0028);
    add(2, 1'b1, 40'h03_0080_0000);
    add(2, 1'b1, 40'h03_0080_000C);
    check_events("f1");

    // Frame 2: completes frame 1, writes bank 0
    capture_sig = 1'b1;
    vsync_pulse();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("f2_u%0d_done", k), 64'(done_cnt[k]), 64'd1);
      chk($sformatf("f2_u%0d_bank", k), 64'(bank[k]), 64'd1);
    end
    video_line(1'b0, 10);
    add_line(0);
    add(0, 1'b1, 40'h04_0000_0000);
    add(0, 1'b1, 40'h04_0000_0010);
    add(1, 1'b1, 40'h04_0000_0000);
    add(1, 1'b1, 40'h02_0000_0010);
    add(2, 1'b1, 40'h03_0000_0000);
    check_events("f2");

    // Frame 3: every command meets a full ctrl FIFO
    vsync_pulse();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("f3_u%0d_done", k), 64'(done_cnt[k]), 64'd2);
      chk($sformatf("f3_u%0d_bank", k), 64'(bank[k]), 64'd0);
      chk($sformatf("f3_u%0d_ovf_pre", k), 64'(ovf[k]), 64'd0);
    end
    ctrl_full = 1'b1;
    video_line(1'b0, 10);
    ctrl_full = 1'b0;
    tick(2);
    add_line(0);
    check_events("f3");
    for (int k = 0; k < 3; k++)
      chk($sformatf("f3_u%0d_ovf", k), 64'(ovf[k]), 64'd1);

    // Reset in the middle of a line abandons the frame
    hsync = 1'b1;
    tick(2);
    hsync = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      de = 1'b1;
      rgb_data = px[i].rgb;
      tick(1);
    end
    rst_n = 1'b0;
    de = 1'b0;
    tick(2);
    @(negedge clk);
    check_idle("midrst");
    #1;
    rst_n = 1'b1;
    tick(2);
    evq.delete();
    vsync_pulse();
    tick(2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("post_u%0d_done", k), 64'(done_cnt[k]), 64'd2);
      chk($sformatf("post_u%0d_bank", k), 64'(bank[k]), 64'd0);
      chk($sformatf("post_u%0d_rtn", k), 64'(rtn[k]), 64'd1);
      chk($sformatf("post_u%0d_ovf", k), 64'(ovf[k]), 64'd0);
    end
    chk("post_no_events", 64'(evq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
